// File: rtl/rank_switch_predictor.sv
// ============================================================================
// Module   : rank_switch_predictor
// Purpose  : Per-rank read-confidence tracking that decides when an NMT write
//            forces a context switch (fixed pulse followed by a cooldown).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rank_switch_predictor #(
    parameter int NUM_RANKS = 4,
    parameter int CNT_W     = 3,
    parameter int THRESH    = 4,
    parameter int MODE      = 1,
    parameter int PULSE_LEN = 1,
    parameter int COOLDOWN  = 4,
    localparam int RANK_W   = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req_valid,
    input  logic              host_req_op,
    input  logic [RANK_W-1:0] host_req_rank,
    input  logic              nmt_op_valid,
    input  logic [1:0]        nmt_op,
    input  logic [RANK_W-1:0] nmt_rank,
    output logic              context_switch,
    output logic [RANK_W-1:0] switch_rank,
    output logic [RANK_W-1:0] predicted_rank,
    output logic [7:0]        suppressed_cnt
);

    localparam int          c_TMR_MAX   = (PULSE_LEN > COOLDOWN) ? PULSE_LEN : COOLDOWN;
    localparam int          c_TMR_W     = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam logic [c_TMR_W-1:0] c_PULSE_LAST = c_TMR_W'(PULSE_LEN - 1);
    localparam logic [c_TMR_W-1:0] c_COOL_LAST  = c_TMR_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;
    localparam logic [31:0]        c_NUM_RANKS  = 32'(NUM_RANKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWITCH = 2'd1,
        S_COOL   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_TMR_W-1:0] w_tmr_nxt;
    logic [CNT_W-1:0]   r_rd_cnt  [NUM_RANKS];
    logic [CNT_W-1:0]   w_cnt_nxt [NUM_RANKS];
    logic [CNT_W-1:0]   w_best;
    logic               r_last_op;
    logic [RANK_W-1:0]  r_switch_rank;
    logic [RANK_W-1:0]  w_switch_rank_nxt;
    logic [RANK_W-1:0]  r_pred;
    logic [RANK_W-1:0]  w_pred;
    logic [7:0]         r_supp;
    logic               w_supp_inc;
    logic               w_host_in_range;
    logic               w_nmt_in_range;
    logic               w_cond;
    logic               w_trig;

    assign w_host_in_range = 32'(host_req_rank) < c_NUM_RANKS;
    assign w_nmt_in_range  = 32'(nmt_rank) < c_NUM_RANKS;

    // Trigger condition sees only registered state, never this cycle's host update
    generate
        if (MODE == 0) begin : g_mode_legacy
            assign w_cond = (r_last_op == 1'b0);
        end else if (THRESH == 0) begin : g_mode_always
            assign w_cond = 1'b1;
        end else begin : g_mode_thresh
            localparam logic [CNT_W-1:0] c_THRESH = CNT_W'(THRESH);
            logic [CNT_W-1:0] w_nmt_cnt;
            assign w_nmt_cnt = w_nmt_in_range ? r_rd_cnt[nmt_rank] : '0;
            assign w_cond    = (w_nmt_cnt >= c_THRESH);
        end
    endgenerate

    assign w_trig = nmt_op_valid & (nmt_op == 2'b00) & w_nmt_in_range & w_cond;

    always_comb begin
        for (int i = 0; i < NUM_RANKS; i++) begin
            w_cnt_nxt[i] = r_rd_cnt[i];
            if (host_req_valid && w_host_in_range && (host_req_rank == RANK_W'(i))) begin
                if (!host_req_op && (r_rd_cnt[i] != c_CNT_MAX)) begin
                    w_cnt_nxt[i] = r_rd_cnt[i] + CNT_W'(1);
                end else if (host_req_op && (r_rd_cnt[i] != '0)) begin
                    w_cnt_nxt[i] = r_rd_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties
    always_comb begin
        w_pred = '0;
        w_best = w_cnt_nxt[0];
        for (int i = 1; i < NUM_RANKS; i++) begin
            if (w_cnt_nxt[i] > w_best) begin
                w_best = w_cnt_nxt[i];
                w_pred = RANK_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_tmr_nxt         = r_tmr;
        w_switch_rank_nxt = r_switch_rank;
        w_supp_inc        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt       = S_SWITCH;
                    w_tmr_nxt         = c_PULSE_LAST;
                    w_switch_rank_nxt = nmt_rank;
                end
            end
            S_SWITCH: begin
                w_supp_inc = w_trig;
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - c_TMR_W'(1);
                end else if (COOLDOWN > 0) begin
                    w_state_nxt = S_COOL;
                    w_tmr_nxt   = c_COOL_LAST;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COOL: begin
                w_supp_inc = w_trig;
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - c_TMR_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_switch_rank <= '0;
            r_pred        <= '0;
            r_supp        <= '0;
            r_last_op     <= 1'b1;
            for (int i = 0; i < NUM_RANKS; i++) begin
                r_rd_cnt[i] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_nxt;
            r_switch_rank <= w_switch_rank_nxt;
            r_pred        <= w_pred;
            if (w_supp_inc && (r_supp != 8'hFF)) begin
                r_supp <= r_supp + 8'd1;
            end
            if (host_req_valid) begin
                r_last_op <= host_req_op;
            end
            for (int i = 0; i < NUM_RANKS; i++) begin
                r_rd_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign context_switch = (r_state == S_SWITCH);
    assign switch_rank    = r_switch_rank;
    assign predicted_rank = r_pred;
    assign suppressed_cnt = r_supp;

endmodule

`default_nettype wire

// File: tb/tb_rank_switch_predictor.sv
// ============================================================================
// Module   : tb_rank_switch_predictor
// Purpose  : Scoreboard bench driving four differently-parameterised copies.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rank_switch_predictor;

    localparam int P_NR  [4] = '{4, 4, 4, 3};
    localparam int P_MODE[4] = '{1, 0, 1, 1};
    localparam int P_THR [4] = '{4, 4, 4, 0};
    localparam int P_PL  [4] = '{1, 1, 3, 2};
    localparam int P_CD  [4] = '{4, 4, 4, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic       host_req_valid;
    logic       host_req_op;
    logic [1:0] host_req_rank;
    logic       nmt_op_valid;
    logic [1:0] nmt_op;
    logic [1:0] nmt_rank;
    logic       cs  [4];
    logic [1:0] sr  [4];
    logic [1:0] pr  [4];
    logic [7:0] sup [4];

    always #5 clk = ~clk;

    rank_switch_predictor #(.NUM_RANKS(4), .CNT_W(3), .THRESH(4), .MODE(1), .PULSE_LEN(1), .COOLDOWN(4)) u_dut_a (
        .clk(clk), .rst(rst), .host_req_valid(host_req_valid), .host_req_op(host_req_op),
        .host_req_rank(host_req_rank), .nmt_op_valid(nmt_op_valid), .nmt_op(nmt_op), .nmt_rank(nmt_rank),
        .context_switch(cs[0]), .switch_rank(sr[0]), .predicted_rank(pr[0]), .suppressed_cnt(sup[0]));

    rank_switch_predictor #(.NUM_RANKS(4), .CNT_W(3), .THRESH(4), .MODE(0), .PULSE_LEN(1), .COOLDOWN(4)) u_dut_b (
        .clk(clk), .rst(rst), .host_req_valid(host_req_valid), .host_req_op(host_req_op),
        .host_req_rank(host_req_rank), .nmt_op_valid(nmt_op_valid), .nmt_op(nmt_op), .nmt_rank(nmt_rank),
        .context_switch(cs[1]), .switch_rank(sr[1]), .predicted_rank(pr[1]), .suppressed_cnt(sup[1]));

    rank_switch_predictor #(.NUM_RANKS(4), .CNT_W(3), .THRESH(4), .MODE(1), .PULSE_LEN(3), .COOLDOWN(4)) u_dut_c (
        .clk(clk), .rst(rst), .host_req_valid(host_req_valid), .host_req_op(host_req_op),
        .host_req_rank(host_req_rank), .nmt_op_valid(nmt_op_valid), .nmt_op(nmt_op), .nmt_rank(nmt_rank),
        .context_switch(cs[2]), .switch_rank(sr[2]), .predicted_rank(pr[2]), .suppressed_cnt(sup[2]));

    rank_switch_predictor #(.NUM_RANKS(3), .CNT_W(3), .THRESH(0), .MODE(1), .PULSE_LEN(2), .COOLDOWN(0)) u_dut_d (
        .clk(clk), .rst(rst), .host_req_valid(host_req_valid), .host_req_op(host_req_op),
        .host_req_rank(host_req_rank), .nmt_op_valid(nmt_op_valid), .nmt_op(nmt_op), .nmt_rank(nmt_rank),
        .context_switch(cs[3]), .switch_rank(sr[3]), .predicted_rank(pr[3]), .suppressed_cnt(sup[3]));

    typedef struct {
        int k;
        int cs;
        int sr;
        int pr;
        int sup;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state per instance: counters, last op, phase (0 idle, 1 pulse, 2 cool)
    int m_cnt [4][4];
    int m_last[4];
    int m_st  [4];
    int m_tmr [4];
    int m_sr  [4];
    int m_sup [4];
    int m_pred[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit hv, input bit hop, input int hr,
                              input bit nv, input int nop, input int nr);
        bit trig;
        int best;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                for (int j = 0; j < 4; j++) m_cnt[k][j] = 0;
                m_last[k] = 1;
                m_st[k]   = 0;
                m_tmr[k]  = 0;
                m_sr[k]   = 0;
                m_sup[k]  = 0;
                m_pred[k] = 0;
            end else begin
                trig = 1'b0;
                if (nv && nop == 0 && nr < P_NR[k]) begin
                    if (P_MODE[k] == 0) trig = (m_last[k] == 0);
                    else                trig = (m_cnt[k][nr] >= P_THR[k]);
                end
                if (m_st[k] == 0) begin
                    if (trig) begin
                        m_st[k]  = 1;
                        m_tmr[k] = P_PL[k] - 1;
                        m_sr[k]  = nr;
                    end
                end else begin
                    if (trig && m_sup[k] < 255) m_sup[k]++;
                    if (m_tmr[k] > 0) begin
                        m_tmr[k]--;
                    end else if (m_st[k] == 1 && P_CD[k] > 0) begin
                        m_st[k]  = 2;
                        m_tmr[k] = P_CD[k] - 1;
                    end else begin
                        m_st[k] = 0;
                    end
                end
                if (hv) begin
                    if (hr < P_NR[k]) begin
                        if (!hop && m_cnt[k][hr] < 7) m_cnt[k][hr]++;
                        if (hop && m_cnt[k][hr] > 0)  m_cnt[k][hr]--;
                    end
                    m_last[k] = hop;
                end
                best = -1;
                for (int j = 0; j < P_NR[k]; j++) begin
                    if (m_cnt[k][j] > best) begin
                        best      = m_cnt[k][j];
                        m_pred[k] = j;
                    end
                end
            end
            e.k   = k;
            e.cs  = (m_st[k] == 1) ? 1 : 0;
            e.sr  = m_sr[k];
            e.pr  = m_pred[k];
            e.sup = m_sup[k];
            sb.push_back(e);
        end
    endtask

    task automatic tick(input bit r, input bit hv, input bit hop, input int hr,
                        input bit nv, input int nop, input int nr);
        exp_t e;
        rst            = r;
        host_req_valid = hv;
        host_req_op    = hop;
        host_req_rank  = 2'(hr);
        nmt_op_valid   = nv;
        nmt_op         = 2'(nop);
        nmt_rank       = 2'(nr);
        model_step(r, hv, hop, hr, nv, nop, nr);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("cs%0d", e.k),  32'(cs[e.k]),  32'(e.cs));
                check($sformatf("sr%0d", e.k),  32'(sr[e.k]),  32'(e.sr));
                check($sformatf("pr%0d", e.k),  32'(pr[e.k]),  32'(e.pr));
                check($sformatf("sup%0d", e.k), 32'(sup[e.k]), 32'(e.sup));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int rank);
        tick(0, 1, 0, rank, 0, 0, 0);
    endtask

    task automatic wr(input int rank);
        tick(0, 1, 1, rank, 0, 0, 0);
    endtask

    task automatic nw(input int rank);
        tick(0, 0, 0, 0, 1, 0, rank);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; host_req_valid = 1'b0; host_req_op = 1'b0; host_req_rank = '0;
        nmt_op_valid = 1'b0; nmt_op = '0; nmt_rank = '0;

        // Five reads then a write-trigger on rank 2
        do_reset();
        for (int i = 0; i < 5; i++) rd(2);
        nw(2);
        check("t1_pulse", 32'(cs[0]), 32'd1);
        check("t1_rank", 32'(sr[0]), 32'd2);
        check("t1_pred", 32'(pr[0]), 32'd2);
        idle(1);
        check("t1_pulse_end", 32'(cs[0]), 32'd0);
        idle(6);

        // Threshold edge with same-cycle host read
        do_reset();
        for (int i = 0; i < 3; i++) rd(1);
        nw(1);
        tick(0, 1, 0, 1, 1, 0, 1);
        check("t2_no_bypass", 32'(cs[0]), 32'd0);
        nw(1);
        check("t2_pulse", 32'(cs[0]), 32'd1);
        idle(6);

        // Back-to-back triggers through pulse and cooldown (rank 3 out of range on d)
        do_reset();
        for (int i = 0; i < 4; i++) rd(3);
        for (int i = 0; i < 7; i++) nw(3);
        idle(6);
        check("t3_supp", 32'(sup[0]), 32'd5);

        // Saturation and floor
        do_reset();
        for (int i = 0; i < 10; i++) rd(0);
        for (int i = 0; i < 9; i++) wr(0);
        check("t4_pred", 32'(pr[0]), 32'd0);
        rd(1);
        check("t4_pred_r1", 32'(pr[0]), 32'd1);

        // Legacy last-op mode
        do_reset();
        wr(0);
        nw(0);
        check("t5_wr_nopulse", 32'(cs[1]), 32'd0);
        idle(6);
        rd(1);
        nw(0);
        check("t5_rd_pulse", 32'(cs[1]), 32'd1);
        idle(6);
        rd(1);
        tick(0, 0, 0, 0, 1, 1, 0);
        check("t5_op01", 32'(cs[1]), 32'd0);
        idle(6);

        // Reset mid-pulse
        do_reset();
        for (int i = 0; i < 4; i++) rd(0);
        nw(0);
        idle(1);
        check("t6_in_pulse", 32'(cs[2]), 32'd1);
        tick(1, 0, 0, 0, 0, 0, 0);
        check("t6_abort", 32'(cs[2]), 32'd0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0 ? 1 : 0,
                 $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rank_switch_predictor.md
Name: rank_switch_predictor

Overview:
- Parametrised successor of the single-rank next-rank predictor.
- Tracks host read/write behaviour per DRAM rank and decides when an incoming NMT write should force a context switch.
- Emits a registered, fixed-length context_switch pulse tagged with the target rank, followed by a programmable cooldown.
- Sits between the host request decoder and the NMT thread scheduler.

Parameters:
- NUM_RANKS, 4: number of ranks tracked; RANK_W = max(1, $clog2(NUM_RANKS)).
- CNT_W, 3: width of each per-rank saturating read-confidence counter.
- THRESH, 4: MODE 1 trigger threshold; valid range 0..2^CNT_W-1.
- MODE, 1: 0 = legacy (trigger if last global host op was READ); 1 = per-rank counter threshold.
- PULSE_LEN, 1: cycles context_switch stays high (>=1).
- COOLDOWN, 4: cycles after the pulse during which triggers are suppressed (0 allowed).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- host_req_valid  in  1  host request present this cycle.
- host_req_op  in  1  0 = READ, 1 = WRITE.
- host_req_rank  in  RANK_W  rank addressed by host request.
- nmt_op_valid  in  1  NMT operation present this cycle.
- nmt_op  in  2  NMT opcode; 2'b00 = NMT_WRITE.
- nmt_rank  in  RANK_W  rank addressed by NMT op.
- context_switch  out  1  switch pulse.
- switch_rank  out  RANK_W  rank of the triggering NMT op; valid while context_switch = 1.
- predicted_rank  out  RANK_W  rank with the highest read counter.
- suppressed_cnt  out  8  saturating count of triggers dropped in SWITCH or COOL.

Behaviour:
- Reset (rst = 1 at posedge): all counters = 0; last_op = WRITE; FSM = IDLE; context_switch = 0; switch_rank = 0; predicted_rank = 0; suppressed_cnt = 0. Reset mid-pulse or mid-cooldown aborts immediately, so the next cycle shows outputs at reset values.
- Host tracking, on host_req_valid with host_req_rank < NUM_RANKS:
  - READ increments rd_cnt[rank], saturating at 2^CNT_W-1.
  - WRITE decrements rd_cnt[rank], saturating at 0.
  - last_op <= host_req_op.
  - Out-of-range rank: counters unchanged, last_op still updated.
- Trigger, evaluated combinationally from state before this cycle's host update (no same-cycle bypass). trig = nmt_op_valid & nmt_op == 2'b00 & nmt_rank < NUM_RANKS & cond, where:
  - cond = (last_op == READ) for MODE 0.
  - cond = (rd_cnt[nmt_rank] >= THRESH) for MODE 1.
- FSM states IDLE, SWITCH, COOL:
  - IDLE: if trig, go to SWITCH and load pulse counter = PULSE_LEN-1. context_switch = 1 and switch_rank = nmt_rank appear on the cycle after trig (latency 1).
  - SWITCH: context_switch held high. At the end of PULSE_LEN cycles, go to COOL (counter = COOLDOWN-1) if COOLDOWN > 0, else IDLE.
  - COOL: context_switch = 0. After COOLDOWN cycles, go to IDLE. A trig on the final COOL cycle is suppressed; the first acceptable trig is in IDLE.
  - In SWITCH or COOL, any trig increments suppressed_cnt, saturating at 255. switch_rank holds its value.
- predicted_rank: registered each cycle as argmax of post-update rd_cnt, lowest index on ties; all zero gives 0.
- Simultaneous host op and NMT op on the same rank: the trigger uses the old counter value; the counter updates in the same edge.
- THRESH = 0 in MODE 1: every valid in-range NMT_WRITE triggers.

Test Plan:
1. Reset, then 5 host READs to rank 2; NMT_WRITE to rank 2 (MODE 1, THRESH 4) -> context_switch high exactly 1 cycle, one cycle later, switch_rank = 2; predicted_rank = 2.
2. 3 READs to rank 1, then NMT_WRITE to rank 1 -> no pulse (3 < 4). A 4th READ in the same cycle as the NMT op -> still no pulse. The next NMT_WRITE -> pulse.
3. Trigger, then NMT_WRITE triggers on every cycle for 6 cycles (PULSE_LEN 1, COOLDOWN 4) -> single pulse; suppressed_cnt = 5 (1 in SWITCH + 4 in COOL... per cycle count); the next trig after COOL is accepted.
4. 10 READs to rank 0 -> rd_cnt saturates at 7. Then 9 WRITEs -> counter floors at 0; predicted_rank = 0 via tie rule.
5. MODE 0: host WRITE, then NMT_WRITE -> no pulse. Host READ, then NMT_WRITE -> pulse. NMT op 2'b01 after READ -> no pulse.
6. Assert rst during the pulse with PULSE_LEN 3 -> context_switch = 0 on the next cycle, all counters = 0, last_op = WRITE, FSM in IDLE.
